// File: rtl/nivel_caixa_ctrl.sv
// Tank level controller: synchronizes and debounces thermometer-coded level sensors,
// drives the inlet valve and flags invalid sensor codes and fill timeouts.
module nivel_caixa_ctrl #(
    parameter int N_SENS = 3,
    parameter int DEB    = 4,
    parameter int LOW_TH = 1,
    parameter int TMO    = 16
) (
    input  logic                            Clk,
    input  logic                            Rst_n,
    input  logic [N_SENS-1:0]               Sens,
    input  logic                            Err_Clr,
    output logic                            Ve,
    output logic                            Al,
    output logic                            Err,
    output logic [$clog2(N_SENS+1)-1:0]     Nivel,
    output logic                            Nv_Critico,
    output logic                            Nv_Cheio,
    output logic [1:0]                      Estado
);

    localparam int W     = $clog2(N_SENS + 1);
    localparam int CNT_W = (DEB > 1) ? $clog2(DEB) : 1;
    localparam int TMO_W = $clog2(TMO + 1);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEB - 1);
    localparam logic [TMO_W-1:0] TMO_V   = TMO_W'(TMO);
    localparam logic [W-1:0]     LOW_V   = W'(LOW_TH);
    localparam logic [W-1:0]     FULL_V  = W'(N_SENS);

    localparam logic [1:0] OCIOSO   = 2'd0;
    localparam logic [1:0] ENCHENDO = 2'd1;
    localparam logic [1:0] ERRO     = 2'd2;

    function automatic logic [W-1:0] f_popcount(input logic [N_SENS-1:0] v);
        logic [W-1:0] c;
        c = '0;
        for (int i = 0; i < N_SENS; i++) c = c + W'(v[i]);
        return c;
    endfunction

    // A 1 directly above a 0 anywhere breaks the thermometer code.
    function automatic logic f_is_thermo(input logic [N_SENS-1:0] v);
        logic ok;
        ok = 1'b1;
        for (int i = 1; i < N_SENS; i++) begin
            if (v[i] && !v[i-1]) ok = 1'b0;
        end
        return ok;
    endfunction

    logic [N_SENS-1:0] r_sync1;
    logic [N_SENS-1:0] r_sync2;
    logic [N_SENS-1:0] r_cand;
    logic [CNT_W-1:0]  r_cnt;
    logic [N_SENS-1:0] r_sens_f;
    logic [W-1:0]      r_nivel_last;
    logic [1:0]        r_state;
    logic [TMO_W-1:0]  r_tmo;
    logic              r_err;

    logic              w_valid;
    logic [W-1:0]      w_pop;
    logic [W-1:0]      w_nivel;
    logic [1:0]        w_next;

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= Sens;
            r_sync2 <= r_sync1;
        end
    end

    // Sens_f only takes a vector that has stayed identical for DEB consecutive compares.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            r_cand   <= '0;
            r_cnt    <= '0;
            r_sens_f <= '0;
        end else if (r_sync2 != r_cand) begin
            r_cand <= r_sync2;
            r_cnt  <= '0;
        end else if (r_cnt < CNT_MAX) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end else begin
            r_sens_f <= r_cand;
        end
    end

    assign w_valid = f_is_thermo(r_sens_f);
    assign w_pop   = f_popcount(r_sens_f);
    assign w_nivel = w_valid ? w_pop : r_nivel_last;

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            r_nivel_last <= '0;
        end else if (w_valid) begin
            r_nivel_last <= w_pop;
        end
    end

    always_comb begin
        w_next = r_state;
        if (!w_valid) begin
            w_next = ERRO;
        end else begin
            case (r_state)
                OCIOSO:   if (w_nivel <= LOW_V) w_next = ENCHENDO;
                ENCHENDO: begin
                    if (w_nivel == FULL_V)    w_next = OCIOSO;
                    else if (r_tmo == TMO_V)  w_next = ERRO;
                end
                ERRO:     if (Err_Clr) w_next = OCIOSO;
                default:  w_next = OCIOSO;
            endcase
        end
    end

    // Timeout restarts whenever the filling state is (re)entered or the level rises.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            r_state <= OCIOSO;
            r_tmo   <= '0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_next;
            r_err   <= (w_next == ERRO);
            if (r_state != ENCHENDO) begin
                r_tmo <= '0;
            end else if (w_valid && (w_pop > r_nivel_last)) begin
                r_tmo <= '0;
            end else if (r_tmo != TMO_V) begin
                r_tmo <= r_tmo + TMO_W'(1);
            end
        end
    end

    assign Nivel      = w_nivel;
    assign Nv_Critico = w_valid && (w_nivel == '0);
    assign Nv_Cheio   = (w_nivel == FULL_V);
    assign Ve         = (r_state == ENCHENDO);
    assign Err        = r_err;
    assign Al         = r_err | Nv_Critico;
    assign Estado     = r_state;

endmodule

// File: tb/tb_nivel_caixa_ctrl.sv
// Bench for nivel_caixa_ctrl: directed scenarios plus random sensor traffic,
// every cycle compared against a cycle-level behavioural model of the controller.
module tb_nivel_caixa_ctrl;

    localparam int N_SENS = 3;
    localparam int DEB    = 4;
    localparam int LOW_TH = 1;
    localparam int TMO    = 16;

    logic       Clk = 1'b0;
    logic       Rst_n;
    logic [2:0] Sens;
    logic       Err_Clr;
    logic       Ve, Al, Err, Nv_Critico, Nv_Cheio;
    logic [1:0] Nivel;
    logic [1:0] Estado;

    int n_cmp  = 0;
    int n_fail = 0;

    // Model state: sampled input history (index 0 newest), filtered vector, FSM view.
    logic [2:0] hist[$];
    logic [2:0] m_sf;
    int         m_last;
    int         m_state;
    int         m_tmo;
    bit         m_err;

    nivel_caixa_ctrl #(
        .N_SENS(N_SENS), .DEB(DEB), .LOW_TH(LOW_TH), .TMO(TMO)
    ) dut (
        .Clk(Clk), .Rst_n(Rst_n), .Sens(Sens), .Err_Clr(Err_Clr),
        .Ve(Ve), .Al(Al), .Err(Err), .Nivel(Nivel),
        .Nv_Critico(Nv_Critico), .Nv_Cheio(Nv_Cheio), .Estado(Estado)
    );

    always #5 Clk = ~Clk;

    function automatic int popc(input logic [2:0] v);
        return int'(v[0]) + int'(v[1]) + int'(v[2]);
    endfunction

    function automatic bit thermo(input logic [2:0] v);
        return ((1 << popc(v)) - 1) == int'(v);
    endfunction

    task automatic model_reset();
        hist = {};
        for (int i = 0; i < DEB + 3; i++) hist.push_back(3'b000);
        m_sf    = 3'b000;
        m_last  = 0;
        m_state = 0;
        m_tmo   = 0;
        m_err   = 1'b0;
    endtask

    task automatic model_edge();
        bit val;
        int pv, niv, nxt;
        bit stable;
        val = thermo(m_sf);
        pv  = popc(m_sf);
        niv = val ? pv : m_last;
        if (!val)                nxt = 2;
        else if (m_state == 0)   nxt = (niv <= LOW_TH) ? 1 : 0;
        else if (m_state == 1)   nxt = (niv == N_SENS) ? 0 : ((m_tmo >= TMO) ? 2 : 1);
        else                     nxt = Err_Clr ? 0 : 2;
        if (m_state != 1)                 m_tmo = 0;
        else if (val && pv > m_last)      m_tmo = 0;
        else if (m_tmo < TMO)             m_tmo = m_tmo + 1;
        m_err = (nxt == 2);
        if (val) m_last = pv;
        m_state = nxt;
        hist.push_front(Sens);
        void'(hist.pop_back());
        // The filtered vector follows the input seen two cycles ago once it has been
        // identical for DEB+1 consecutive samples.
        stable = 1'b1;
        for (int i = 3; i <= 2 + DEB; i++) if (hist[i] != hist[2]) stable = 1'b0;
        if (stable) m_sf = hist[2];
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string ph);
        bit val;
        int niv;
        bit crit;
        val  = thermo(m_sf);
        niv  = val ? popc(m_sf) : m_last;
        crit = val && (niv == 0);
        check({ph, ".nivel"},  32'(Nivel),      32'(niv));
        check({ph, ".estado"}, 32'(Estado),     32'(m_state));
        check({ph, ".ve"},     32'(Ve),         32'(m_state == 1));
        check({ph, ".err"},    32'(Err),        32'(m_err));
        check({ph, ".crit"},   32'(Nv_Critico), 32'(crit));
        check({ph, ".cheio"},  32'(Nv_Cheio),   32'(niv == N_SENS));
        check({ph, ".al"},     32'(Al),         32'(m_err | crit));
    endtask

    task automatic tick(input string ph);
        @(posedge Clk);
        model_edge();
        #1;
        check_all(ph);
    endtask

    task automatic hold(input logic [2:0] v, input int n, input string ph);
        Sens = v;
        for (int i = 0; i < n; i++) tick(ph);
    endtask

    initial begin
        Rst_n   = 1'b0;
        Sens    = 3'b000;
        Err_Clr = 1'b0;
        model_reset();
        repeat (2) @(posedge Clk);
        #3;
        check_all("reset");
        check("reset.al_const", 32'(Al), 32'd1);
        Rst_n = 1'b1;

        tick("start");
        check("start.ve_first_edge", 32'(Ve), 32'd1);
        tick("start");

        hold(3'b001, 12, "fill1");
        hold(3'b011, 12, "fill2");
        check("fill.ve_mid", 32'(Ve), 32'd1);
        hold(3'b111, 12, "fill3");
        check("fill.nivel_end", 32'(Nivel), 32'd3);
        check("fill.estado_end", 32'(Estado), 32'd0);
        check("fill.ve_end", 32'(Ve), 32'd0);

        hold(3'b011, 12, "glitch_pre");
        hold(3'b111, 3, "glitch_pulse");
        hold(3'b011, 12, "glitch_post");
        check("glitch.nivel", 32'(Nivel), 32'd2);
        check("glitch.ve", 32'(Ve), 32'd0);

        hold(3'b101, 10, "invalid");
        check("invalid.estado", 32'(Estado), 32'd2);
        check("invalid.err", 32'(Err), 32'd1);
        check("invalid.al", 32'(Al), 32'd1);
        check("invalid.nivel_hold", 32'(Nivel), 32'd2);

        Err_Clr = 1'b1;
        hold(3'b101, 2, "clr_invalid");
        check("clr_invalid.err", 32'(Err), 32'd1);
        Err_Clr = 1'b0;
        hold(3'b011, 10, "clr_wait");
        Err_Clr = 1'b1;
        tick("clr_ok");
        Err_Clr = 1'b0;
        check("clr_ok.estado", 32'(Estado), 32'd0);
        check("clr_ok.err", 32'(Err), 32'd0);

        hold(3'b001, 30, "timeout");
        check("timeout.estado", 32'(Estado), 32'd2);
        check("timeout.err", 32'(Err), 32'd1);
        check("timeout.ve", 32'(Ve), 32'd0);
        Err_Clr = 1'b1;
        tick("tmo_clr");
        Err_Clr = 1'b0;
        tick("refill");
        check("refill.ve", 32'(Ve), 32'd1);

        #3;
        Rst_n = 1'b0;
        #1;
        check("areset.ve", 32'(Ve), 32'd0);
        check("areset.err", 32'(Err), 32'd0);
        check("areset.estado", 32'(Estado), 32'd0);
        model_reset();
        repeat (2) @(posedge Clk);
        #1;
        check_all("in_reset");
        #3;
        Rst_n = 1'b1;

        for (int seg = 0; seg < 40; seg++) begin
            logic [2:0] v;
            int n;
            if ($urandom_range(0, 9) < 8) v = 3'((1 << $urandom_range(0, 3)) - 1);
            else                          v = 3'($urandom_range(0, 7));
            n    = $urandom_range(1, 14);
            Sens = v;
            for (int i = 0; i < n; i++) begin
                Err_Clr = ($urandom_range(0, 3) == 0);
                tick("random");
            end
        end
        Err_Clr = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
